// File: rtl/sdad_pkg.sv
// Shared types for the sweep sequencer: FSM states, word widths and the
// sweep-table entry layout.
package sdad_pkg;

  localparam int FRQ_W   = 14;
  localparam int DWELL_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2
  } state_t;

  typedef struct packed {
    logic [FRQ_W-1:0]   frq;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/sweep_seq_tick_gen.sv
// Dwell time-base prescaler: one-cycle tick every C_CLK_FRQ/C_TICK_FRQ clocks.
// The cycle in which clr is high counts as the first cycle of the new period.
module tick_gen #(
  parameter int C_CLK_FRQ  = 100000000,
  parameter int C_TICK_FRQ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = (C_CLK_FRQ / C_TICK_FRQ < 1) ? 1 : C_CLK_FRQ / C_TICK_FRQ;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP   = CW'(DIV - 1);
  localparam logic [CW-1:0] RELD  = (DIV > 1) ? CW'(1) : '0;

  logic [CW-1:0] cnt_q;

  assign tick = !clr && (cnt_q == TOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= RELD;
    else if (cnt_q == TOP)
      cnt_q <= '0;
    else
      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/sweep_seq.sv
// Frequency sweep sequencer: steps a small programmable table of
// (frequency, dwell) entries and drives the sine generator frequency word.
module sweep_seq
  import sdad_pkg::*;
#(
  parameter int C_CLK_FRQ  = 100000000,
  parameter int C_TICK_FRQ = 1000,
  parameter int C_STEPS    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop,
  input  logic                       cfg_we,
  input  logic [$clog2(C_STEPS)-1:0] cfg_addr,
  input  logic [FRQ_W-1:0]           cfg_frq,
  input  logic [DWELL_W-1:0]         cfg_dwell,
  output logic [FRQ_W-1:0]           frq,
  output logic                       frq_stb,
  output logic [$clog2(C_STEPS)-1:0] step,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int AW = $clog2(C_STEPS);
  localparam logic [AW-1:0] LAST = AW'(C_STEPS - 1);

  entry_t               tbl_q [C_STEPS];
  state_t               state_q;
  logic [AW-1:0]        idx_q;
  logic [AW-1:0]        step_q;
  logic [DWELL_W-1:0]   dcnt_q;
  logic [FRQ_W-1:0]     frq_q;
  logic                 stb_q;
  logic                 done_q;
  logic                 err_q;

  entry_t               cur;
  logic                 tick;
  logic                 dwell_end;
  state_t               adv_state_d;
  logic [AW-1:0]        adv_idx_d;
  logic                 adv_done_d;

  assign cur       = tbl_q[idx_q];
  assign dwell_end = tick && ((dcnt_q + 1'b1) == cur.dwell);

  tick_gen #(
    .C_CLK_FRQ  (C_CLK_FRQ),
    .C_TICK_FRQ (C_TICK_FRQ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == S_LOAD),
    .tick (tick)
  );

  // Where the sweep goes once the current entry is finished or skipped.
  always_comb begin
    adv_state_d = S_LOAD;
    adv_idx_d   = idx_q + 1'b1;
    adv_done_d  = 1'b0;
    if (idx_q == LAST) begin
      adv_idx_d = '0;
      if (!loop) begin
        adv_state_d = S_IDLE;
        adv_done_d  = 1'b1;
      end
    end
  end

  // Table is writable only while idle; the write lands on the same edge that
  // accepts start, so the first LOAD already sees it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_STEPS; i++)
        tbl_q[i] <= '0;
    end else if (cfg_we && (state_q == S_IDLE)) begin
      tbl_q[cfg_addr] <= '{frq: cfg_frq, dwell: cfg_dwell};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      dcnt_q  <= '0;
      frq_q   <= '0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= cfg_we && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
          end
        end
        S_LOAD: begin
          if (stop) begin
            state_q <= S_IDLE;
            frq_q   <= '0;
            stb_q   <= 1'b1;
          end else begin
            step_q <= idx_q;
            dcnt_q <= '0;
            if (cur.dwell != '0) begin
              frq_q   <= cur.frq;
              stb_q   <= 1'b1;
              state_q <= S_DWELL;
            end else begin
              state_q <= adv_state_d;
              idx_q   <= adv_idx_d;
              done_q  <= adv_done_d;
            end
          end
        end
        S_DWELL: begin
          if (stop) begin
            state_q <= S_IDLE;
            frq_q   <= '0;
            stb_q   <= 1'b1;
          end else if (dwell_end) begin
            state_q <= adv_state_d;
            idx_q   <= adv_idx_d;
            done_q  <= adv_done_d;
          end else if (tick) begin
            dcnt_q <= dcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign frq     = frq_q;
  assign frq_stb = stb_q;
  assign step    = step_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_sweep_seq.sv
// Directed bench for sweep_seq: a per-cycle vector table for idle/config
// behaviour, then recorded multi-cycle sweeps compared against hand timelines.
module tb_sweep_seq;

  logic        clk, rst, start, stop, loop, cfg_we;
  logic [1:0]  cfg_addr;
  logic [13:0] cfg_frq;
  logic [15:0] cfg_dwell;
  logic [13:0] frq;
  logic        frq_stb, busy, done, cfg_err;
  logic [1:0]  step;

  sweep_seq #(.C_CLK_FRQ(1000), .C_TICK_FRQ(100), .C_STEPS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_frq(cfg_frq), .cfg_dwell(cfg_dwell),
    .frq(frq), .frq_stb(frq_stb), .step(step), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int stb_c[$], stb_f[$], stb_s[$];
  int done_n, done_c, err_n, err_c, busy_fall;

  typedef struct {
    logic        start, stop, we;
    logic [1:0]  addr;
    logic [13:0] frq;
    logic [15:0] dwell;
    logic        e_busy, e_stb, e_done, e_err;
    logic [13:0] e_frq;
    logic [1:0]  e_step;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cfg_wr(input int a, input int f, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_frq = 14'(f); cfg_dwell = 16'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Pulse start, then record every frq_stb/done/cfg_err for ncyc cycles.
  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic run(input int ncyc, input int stop_at, input int we_at);
    stb_c.delete(); stb_f.delete(); stb_s.delete();
    done_n = 0; done_c = -1; err_n = 0; err_c = -1; busy_fall = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (frq_stb) begin
        stb_c.push_back(c); stb_f.push_back(int'(frq)); stb_s.push_back(int'(step));
      end
      if (done) begin done_n++; done_c = c; end
      if (cfg_err) begin err_n++; err_c = c; end
      if (!busy && busy_fall < 0) busy_fall = c;
      stop   = (c == stop_at);
      cfg_we = (c == we_at);
      cfg_addr = 2'd2; cfg_frq = 14'd999; cfg_dwell = 16'd9;
    end
    stop = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int n,
                           input int ec[8], input int ef[8], input int es[8]);
    chk({tag, ".nstb"}, stb_c.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < stb_c.size()) begin
        chk($sformatf("%s.stb%0d.cyc", tag, i), stb_c[i], ec[i]);
        chk($sformatf("%s.stb%0d.frq", tag, i), stb_f[i], ef[i]);
        chk($sformatf("%s.stb%0d.step", tag, i), stb_s[i], es[i]);
      end
    end
  endtask

  task automatic check_full(input string tag);
    check_seq(tag, 4, '{2, 22, 32, 62, 0, 0, 0, 0},
                      '{10, 100, 200, 5, 0, 0, 0, 0},
                      '{0, 1, 2, 3, 0, 0, 0, 0});
    chk({tag, ".ndone"}, done_n, 1);
    chk({tag, ".done_cyc"}, done_c, 71);
    chk({tag, ".busy_fall"}, busy_fall, 71);
    chk({tag, ".frq_hold"}, int'(frq), 5);
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; loop = 0; cfg_we = 0;
    cfg_addr = 0; cfg_frq = 0; cfg_dwell = 0;

    //          st sp we a  frq  dw  busy stb done err efrq estep
    vt[0]  = '{0, 0, 0, 0,   0, 0,  0, 0, 0, 0,  0, 0};
    vt[1]  = '{0, 1, 0, 0,   0, 0,  0, 0, 0, 0,  0, 0};
    vt[2]  = '{0, 0, 1, 0,  77, 2,  0, 0, 0, 0,  0, 0};
    vt[3]  = '{0, 0, 1, 1, 100, 1,  0, 0, 0, 0,  0, 0};
    vt[4]  = '{0, 0, 1, 2, 200, 3,  0, 0, 0, 0,  0, 0};
    vt[5]  = '{0, 0, 1, 3,   5, 1,  0, 0, 0, 0,  0, 0};
    vt[6]  = '{1, 0, 1, 0,  10, 2,  1, 0, 0, 0,  0, 0};
    vt[7]  = '{0, 0, 0, 0,   0, 0,  1, 1, 0, 0, 10, 0};
    vt[8]  = '{1, 0, 1, 2, 999, 9,  1, 0, 0, 1, 10, 0};
    vt[9]  = '{0, 1, 0, 0,   0, 0,  0, 1, 0, 0,  0, 0};
    vt[10] = '{0, 1, 0, 0,   0, 0,  0, 0, 0, 0,  0, 0};

    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.frq", int'(frq), 0);
    chk("rst.stb", int'(frq_stb), 0);
    chk("rst.step", int'(step), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(cfg_err), 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start = vt[i].start; stop = vt[i].stop; cfg_we = vt[i].we;
      cfg_addr = vt[i].addr; cfg_frq = vt[i].frq; cfg_dwell = vt[i].dwell;
      @(negedge clk);
      start = 0; stop = 0; cfg_we = 0;
      chk($sformatf("v%0d.busy", i), int'(busy), int'(vt[i].e_busy));
      chk($sformatf("v%0d.stb", i), int'(frq_stb), int'(vt[i].e_stb));
      chk($sformatf("v%0d.done", i), int'(done), int'(vt[i].e_done));
      chk($sformatf("v%0d.err", i), int'(cfg_err), int'(vt[i].e_err));
      chk($sformatf("v%0d.frq", i), int'(frq), int'(vt[i].e_frq));
      chk($sformatf("v%0d.step", i), int'(step), int'(vt[i].e_step));
    end

    // full sweep with table {(10,2),(100,1),(200,3),(5,1)}
    run(80, -1, -1);
    check_full("sweep");

    // rejected write while dwelling, then the table must be unchanged
    run(80, -1, 10);
    chk("we_busy.nerr", err_n, 1);
    chk("we_busy.err_cyc", err_c, 11);
    check_full("we_busy");
    run(80, -1, -1);
    check_full("readback");

    // abort during entry 1
    run(40, 25, -1);
    check_seq("stop", 3, '{2, 22, 26, 0, 0, 0, 0, 0},
                         '{10, 100, 0, 0, 0, 0, 0, 0},
                         '{0, 1, 1, 0, 0, 0, 0, 0});
    chk("stop.ndone", done_n, 0);
    chk("stop.busy_fall", busy_fall, 26);
    chk("stop.frq", int'(frq), 0);

    // skipped entry with looping, stopped after the wrap
    cfg_wr(1, 100, 0);
    loop = 1'b1;
    run(130, 120, -1);
    check_seq("loop", 7, '{2, 23, 53, 63, 84, 114, 121, 0},
                         '{10, 200, 5, 10, 200, 5, 0, 0},
                         '{0, 2, 3, 0, 2, 3, 3, 0});
    chk("loop.ndone", done_n, 0);
    chk("loop.busy_fall", busy_fall, 121);
    loop = 1'b0;

    // asynchronous reset mid-dwell clears outputs and the table
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("arst.pre_busy", int'(busy), 1);
    chk("arst.pre_frq", int'(frq), 10);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", int'(busy), 0);
    chk("arst.frq", int'(frq), 0);
    chk("arst.stb", int'(frq_stb), 0);
    chk("arst.step", int'(step), 0);
    chk("arst.done", int'(done), 0);
    chk("arst.err", int'(cfg_err), 0);
    @(negedge clk);
    rst = 1'b0;
    run(20, -1, -1);
    chk("cleared.nstb", stb_c.size(), 0);
    chk("cleared.ndone", done_n, 1);
    chk("cleared.done_cyc", done_c, 5);
    chk("cleared.busy_fall", busy_fall, 5);
    chk("cleared.frq", int'(frq), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
